// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the parametrised single-clock FIFO family.
package fifo_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 256;
    localparam int DEF_MARGIN = 4;

    // Ceiling log2; used for pointer widths at elaboration time.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port register array: synchronous write, registered or asynchronous read.
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int SHOW_AHEAD = 0,
    parameter int AW         = clog2(DEPTH)
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              i_sclr,
    input  logic              i_wr_en,
    input  logic [AW-1:0]     i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    input  logic [AW-1:0]     i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rd_data;

    // Storage is intentionally not reset so it can map onto plain registers or LUT RAM.
    always_ff @(posedge sys_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_rd_data <= '0;
        end else if (i_sclr) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    // Show-ahead presents the head word combinationally; the register is then unused.
    assign o_rd_data = (SHOW_AHEAD != 0) ? r_mem[i_rd_addr] : r_rd_data;

endmodule

// File: rtl/scfifo_param.sv
// Parametrised single-clock FIFO: pointers, fill counter, flag decode and error pulses.
module scfifo_param
    import fifo_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int SHOW_AHEAD = 0,
    parameter int AF_LEVEL   = DEPTH - DEF_MARGIN,
    parameter int AE_LEVEL   = DEF_MARGIN,
    localparam int AW        = clog2(DEPTH)
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              sclr,
    input  logic              wr_req,
    input  logic [DATA_W-1:0] pi_data,
    input  logic              rd_req,
    output logic [DATA_W-1:0] po_data,
    output logic              empty,
    output logic              full,
    output logic              almost_empty,
    output logic              almost_full,
    output logic [AW:0]       usedw,
    output logic              wr_err,
    output logic              rd_err
);

    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   AF_CNT   = (AW+1)'(AF_LEVEL);
    localparam logic [AW:0]   AE_CNT   = (AW+1)'(AE_LEVEL);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_usedw;
    logic          r_wr_err;
    logic          r_rd_err;
    logic          w_wr_acc;
    logic          w_rd_acc;
    logic          w_ram_wr;
    logic          w_ram_rd;

    // Requests have no backpressure: a request is taken on the edge only if the
    // registered flags allow it; otherwise it is dropped and flagged next cycle.
    assign w_wr_acc = wr_req && !full;
    assign w_rd_acc = rd_req && !empty;
    assign w_ram_wr = w_wr_acc && !sclr;
    assign w_ram_rd = w_rd_acc && !sclr;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_usedw  <= '0;
            r_wr_err <= 1'b0;
            r_rd_err <= 1'b0;
        end else if (sclr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_usedw  <= '0;
            r_wr_err <= 1'b0;
            r_rd_err <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_usedw <= r_usedw + CNT_ONE;
                2'b01:   r_usedw <= r_usedw - CNT_ONE;
                default: r_usedw <= r_usedw;
            endcase
            r_wr_err <= wr_req && full;
            r_rd_err <= rd_req && empty;
        end
    end

    // Flags come only from the registered count, never from same-cycle requests.
    assign usedw        = r_usedw;
    assign empty        = (r_usedw == '0);
    assign full         = (r_usedw == FULL_CNT);
    assign almost_empty = (r_usedw < AE_CNT);
    assign almost_full  = (r_usedw >= AF_CNT);
    assign wr_err       = r_wr_err;
    assign rd_err       = r_rd_err;

    fifo_ram #(
        .DATA_W     (DATA_W),
        .DEPTH      (DEPTH),
        .SHOW_AHEAD (SHOW_AHEAD),
        .AW         (AW)
    ) u_ram (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .i_sclr    (sclr),
        .i_wr_en   (w_ram_wr),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (pi_data),
        .i_rd_en   (w_ram_rd),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (po_data)
    );

endmodule

// File: tb/tb_scfifo_param.sv
// Bench for scfifo_param: normal-mode and show-ahead instances against a queue model.
module tb_scfifo_param;

    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int AF    = 6;
    localparam int AE    = 2;
    localparam logic [9:0] RST_STAT = {4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    logic sys_clk;
    logic sys_rst_n;

    logic          n_sclr, n_wr, n_rd;
    logic [DW-1:0] n_din, n_po;
    logic          n_empty, n_full, n_ae, n_af, n_wr_err, n_rd_err;
    logic [3:0]    n_usedw;
    logic [9:0]    n_stat;

    logic          s_sclr, s_wr, s_rd;
    logic [DW-1:0] s_din, s_po;
    logic          s_empty, s_full, s_ae, s_af, s_wr_err, s_rd_err;
    logic [3:0]    s_usedw;
    logic [9:0]    s_stat;

    int checks;
    int failures;

    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] m_po;
    logic          m_werr, m_rerr;
    logic [DW-1:0] sa_q[$];
    logic          sa_werr, sa_rerr;

    assign n_stat = {n_usedw, n_empty, n_full, n_ae, n_af, n_wr_err, n_rd_err};
    assign s_stat = {s_usedw, s_empty, s_full, s_ae, s_af, s_wr_err, s_rd_err};

    scfifo_param #(.DATA_W(DW), .DEPTH(DEPTH), .SHOW_AHEAD(0), .AF_LEVEL(AF), .AE_LEVEL(AE)) u_dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .sclr(n_sclr), .wr_req(n_wr), .pi_data(n_din),
        .rd_req(n_rd), .po_data(n_po), .empty(n_empty), .full(n_full), .almost_empty(n_ae),
        .almost_full(n_af), .usedw(n_usedw), .wr_err(n_wr_err), .rd_err(n_rd_err)
    );

    scfifo_param #(.DATA_W(DW), .DEPTH(DEPTH), .SHOW_AHEAD(1), .AF_LEVEL(AF), .AE_LEVEL(AE)) u_sa (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .sclr(s_sclr), .wr_req(s_wr), .pi_data(s_din),
        .rd_req(s_rd), .po_data(s_po), .empty(s_empty), .full(s_full), .almost_empty(s_ae),
        .almost_full(s_af), .usedw(s_usedw), .wr_err(s_wr_err), .rd_err(s_rd_err)
    );

    // Clock / reset
    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Expected status vector straight from the fill level.
    function automatic logic [9:0] exp_status(input int size, input logic we, input logic re);
        return {4'(size), 1'(size == 0), 1'(size == DEPTH), 1'(size < AE), 1'(size >= AF), we, re};
    endfunction

    task automatic clear_models();
        exp_q.delete();
        sa_q.delete();
        m_po    = '0;
        m_werr  = 1'b0;
        m_rerr  = 1'b0;
        sa_werr = 1'b0;
        sa_rerr = 1'b0;
    endtask

    task automatic idle_inputs();
        n_sclr = 0; n_wr = 0; n_rd = 0; n_din = '0;
        s_sclr = 0; s_wr = 0; s_rd = 0; s_din = '0;
    endtask

    // One clock: model consumes the inputs seen at the edge, then outputs are sampled 1ns later.
    task automatic step();
        bit wr_ok, rd_ok;
        @(posedge sys_clk);
        if (!sys_rst_n) begin
            clear_models();
        end else begin
            if (n_sclr) begin
                exp_q.delete(); m_po = '0; m_werr = 0; m_rerr = 0;
            end else begin
                m_werr = n_wr && (exp_q.size() == DEPTH);
                m_rerr = n_rd && (exp_q.size() == 0);
                wr_ok  = n_wr && (exp_q.size() != DEPTH);
                rd_ok  = n_rd && (exp_q.size() != 0);
                if (rd_ok) m_po = exp_q.pop_front();
                if (wr_ok) exp_q.push_back(n_din);
            end
            if (s_sclr) begin
                sa_q.delete(); sa_werr = 0; sa_rerr = 0;
            end else begin
                sa_werr = s_wr && (sa_q.size() == DEPTH);
                sa_rerr = s_rd && (sa_q.size() == 0);
                wr_ok   = s_wr && (sa_q.size() != DEPTH);
                rd_ok   = s_rd && (sa_q.size() != 0);
                if (rd_ok) void'(sa_q.pop_front());
                if (wr_ok) sa_q.push_back(s_din);
            end
        end
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        sys_rst_n = 1'b0;
        repeat (2) step();
        if (n_stat !== RST_STAT) begin failures++; $display("FAIL reset_status got=%b exp=%b", n_stat, RST_STAT); end
        checks++;
        if (n_po !== 8'h00) begin failures++; $display("FAIL reset_po got=%h exp=00", n_po); end
        checks++;
        if (s_stat !== RST_STAT) begin failures++; $display("FAIL reset_sa_status got=%b exp=%b", s_stat, RST_STAT); end
        checks++;
        #2 sys_rst_n = 1'b1;
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < DEPTH; i++) begin
            n_wr = 1; n_din = 8'(i);
            step();
            if (n_stat !== exp_status(exp_q.size(), m_werr, m_rerr) || n_usedw !== 4'(i + 1)) begin
                failures++; $display("FAIL fill_status i=%0d got=%b exp=%b", i, n_stat, exp_status(i + 1, 0, 0));
            end
            checks++;
        end
        n_wr = 0;
        for (int i = 0; i < DEPTH; i++) begin
            n_rd = 1;
            step();
            if (n_po !== 8'(i)) begin failures++; $display("FAIL drain_data i=%0d got=%h exp=%h", i, n_po, 8'(i)); end
            checks++;
            if (n_stat !== exp_status(exp_q.size(), m_werr, m_rerr)) begin
                failures++; $display("FAIL drain_status i=%0d got=%b exp=%b", i, n_stat, exp_status(exp_q.size(), m_werr, m_rerr));
            end
            checks++;
        end
        n_rd = 0;
    endtask

    task automatic test_overflow();
        for (int i = 0; i < DEPTH; i++) begin
            n_wr = 1; n_din = 8'($urandom_range(0, 8'hA9));
            step();
        end
        if (n_full !== 1'b1) begin failures++; $display("FAIL ovf_full got=%b exp=1", n_full); end
        checks++;
        n_wr = 1; n_rd = 1; n_din = 8'hAA;
        step();
        n_wr = 0; n_rd = 0;
        if (n_wr_err !== 1'b1 || n_usedw !== 4'd7) begin
            failures++; $display("FAIL ovf_err got=wr_err %b usedw %0d exp=wr_err 1 usedw 7", n_wr_err, n_usedw);
        end
        checks++;
        if (n_po !== m_po) begin failures++; $display("FAIL ovf_read got=%h exp=%h", n_po, m_po); end
        checks++;
        step();
        if (n_wr_err !== 1'b0) begin failures++; $display("FAIL ovf_pulse_len got=%b exp=0", n_wr_err); end
        checks++;
        for (int i = 0; i < DEPTH - 1; i++) begin
            n_rd = 1;
            step();
            if (n_po === 8'hAA || n_po !== m_po) begin
                failures++; $display("FAIL ovf_drain i=%0d got=%h exp=%h", i, n_po, m_po);
            end
            checks++;
        end
        n_rd = 0;
    endtask

    task automatic test_underflow();
        logic [DW-1:0] prev;
        prev = m_po;
        n_rd = 1; n_wr = 1; n_din = 8'h55;
        step();
        n_rd = 0; n_wr = 0;
        if (n_rd_err !== 1'b1 || n_usedw !== 4'd1 || n_po !== prev) begin
            failures++; $display("FAIL udf_err got=rd_err %b usedw %0d po %h exp=rd_err 1 usedw 1 po %h", n_rd_err, n_usedw, n_po, prev);
        end
        checks++;
        n_rd = 1;
        step();
        n_rd = 0;
        if (n_po !== 8'h55 || n_rd_err !== 1'b0) begin
            failures++; $display("FAIL udf_next got=po %h rd_err %b exp=po 55 rd_err 0", n_po, n_rd_err);
        end
        checks++;
    endtask

    task automatic test_stream();
        for (int i = 0; i < 3; i++) begin
            n_wr = 1; n_din = 8'($urandom);
            step();
        end
        for (int i = 0; i < 20; i++) begin
            n_wr = 1; n_rd = 1; n_din = 8'($urandom);
            step();
            if (n_usedw !== 4'd3 || n_po !== m_po) begin
                failures++; $display("FAIL stream i=%0d got=usedw %0d po %h exp=usedw 3 po %h", i, n_usedw, n_po, m_po);
            end
            checks++;
        end
        n_wr = 0;
        repeat (3) step();
        n_rd = 0;
        step();
        if (n_stat !== exp_status(0, 0, 0)) begin failures++; $display("FAIL stream_end got=%b exp=%b", n_stat, exp_status(0, 0, 0)); end
        checks++;
    endtask

    task automatic test_show_ahead();
        s_wr = 1; s_din = 8'h11;
        step();
        s_wr = 0;
        if (s_po !== 8'h11 || s_empty !== 1'b0) begin failures++; $display("FAIL sa_first got=po %h empty %b exp=po 11 empty 0", s_po, s_empty); end
        checks++;
        s_wr = 1; s_din = 8'h22;
        step();
        s_wr = 0;
        if (s_po !== 8'h11) begin failures++; $display("FAIL sa_hold got=%h exp=11", s_po); end
        checks++;
        s_rd = 1;
        step();
        if (s_po !== 8'h22) begin failures++; $display("FAIL sa_advance got=%h exp=22", s_po); end
        checks++;
        step();
        s_rd = 0;
        if (s_empty !== 1'b1 || s_usedw !== 4'd0) begin failures++; $display("FAIL sa_empty got=empty %b usedw %0d exp=empty 1 usedw 0", s_empty, s_usedw); end
        checks++;
    endtask

    task automatic test_sclr();
        for (int i = 0; i < 5; i++) begin
            n_wr = 1; n_din = 8'($urandom_range(1, 255));
            step();
        end
        n_rd = 1; n_wr = 0;
        step();
        n_rd = 0;
        if (n_usedw !== 4'd4 || n_po === 8'h00) begin failures++; $display("FAIL sclr_setup got=usedw %0d po %h exp=usedw 4 po nonzero", n_usedw, n_po); end
        checks++;
        n_wr = 1; n_din = 8'h77;
        step();
        n_sclr = 1; n_wr = 1; n_din = 8'h99;
        step();
        n_sclr = 0; n_wr = 0;
        if (n_stat !== RST_STAT || n_po !== 8'h00) begin
            failures++; $display("FAIL sclr_clear got=stat %b po %h exp=stat %b po 00", n_stat, n_po, RST_STAT);
        end
        checks++;
        n_wr = 1; n_din = 8'h3C;
        step();
        n_wr = 0; n_rd = 1;
        step();
        n_rd = 0;
        if (n_po !== 8'h3C || n_empty !== 1'b1) begin failures++; $display("FAIL sclr_after got=po %h empty %b exp=po 3c empty 1", n_po, n_empty); end
        checks++;
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 5; i++) begin
            n_wr = 1; n_din = 8'($urandom_range(1, 255));
            s_wr = 1; s_din = 8'($urandom);
            step();
        end
        n_wr = 0; s_wr = 0; n_rd = 1;
        step();
        n_rd = 0;
        #3 sys_rst_n = 1'b0;
        #1;
        clear_models();
        if (n_stat !== RST_STAT || n_po !== 8'h00) begin
            failures++; $display("FAIL async_rst got=stat %b po %h exp=stat %b po 00", n_stat, n_po, RST_STAT);
        end
        checks++;
        if (s_stat !== RST_STAT) begin failures++; $display("FAIL async_rst_sa got=%b exp=%b", s_stat, RST_STAT); end
        checks++;
        #2 sys_rst_n = 1'b1;
        n_wr = 1; n_din = 8'h5A; s_wr = 1; s_din = 8'h5A;
        step();
        n_wr = 0; s_wr = 0; n_rd = 1;
        if (s_po !== 8'h5A || s_usedw !== 4'd1) begin failures++; $display("FAIL async_rst_sa_first got=po %h usedw %0d exp=po 5a usedw 1", s_po, s_usedw); end
        checks++;
        step();
        n_rd = 0;
        if (n_po !== 8'h5A) begin failures++; $display("FAIL async_rst_first got=%h exp=5a", n_po); end
        checks++;
        s_rd = 1;
        step();
        s_rd = 0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            n_wr = 1'($urandom_range(0, 99) < 55); n_rd = 1'($urandom_range(0, 99) < 45);
            n_din = 8'($urandom); n_sclr = 1'($urandom_range(0, 39) == 0);
            s_wr = 1'($urandom_range(0, 99) < 50); s_rd = 1'($urandom_range(0, 99) < 50);
            s_din = 8'($urandom); s_sclr = 1'($urandom_range(0, 39) == 0);
            step();
            if (n_stat !== exp_status(exp_q.size(), m_werr, m_rerr) || n_po !== m_po) begin
                failures++; $display("FAIL rand_norm i=%0d got=stat %b po %h exp=stat %b po %h", i, n_stat, n_po, exp_status(exp_q.size(), m_werr, m_rerr), m_po);
            end
            checks++;
            if (s_stat !== exp_status(sa_q.size(), sa_werr, sa_rerr)) begin
                failures++; $display("FAIL rand_sa_stat i=%0d got=%b exp=%b", i, s_stat, exp_status(sa_q.size(), sa_werr, sa_rerr));
            end
            checks++;
            if (sa_q.size() != 0) begin
                if (s_po !== sa_q[0]) begin failures++; $display("FAIL rand_sa_data i=%0d got=%h exp=%h", i, s_po, sa_q[0]); end
                checks++;
            end
        end
        idle_inputs();
        step();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        clear_models();
        test_reset();
        test_fill_drain();
        test_overflow();
        test_underflow();
        test_stream();
        test_show_ahead();
        test_sclr();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
